alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 SHALL expose these ports; clock and reset come first.
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  instr_valid  in  1  instruction offered
  instr  in  16  instruction word
  instr_ready  out  1  sequencer accepts instr this cycle
  result_ready  in  1  consumer accepts result
  result_valid  out  1  result word available
  result  out  8  output data
  alu_a  out  8  ALU operand a
  alu_b  out  8  ALU operand b
  alu_carry  out  1  ALU carry in
  alu_op  out  4  ALU opcode
  alu_c  in  8  ALU result
  alu_carry_out  in  1  ALU carry out
  alu_zero  in  1  ALU zero flag
  flag_c  out  1  registered carry flag
  flag_z  out  1  registered zero flag
REQ-003 SHALL have parameter RESET_VAL, default 8'h00, giving the reset value of every register-file entry.

Function
REQ-010 SHALL hold four 8-bit registers, r0 to r3.
REQ-011 SHALL decode the instruction class from instr[15:14]: 00 ALU, 01 LOADI, 10 OUT, 11 NOP.
REQ-012 SHALL use these ALU-class fields: op=[13:10], dst=[9:8], srcA=[7:6], srcB=[5:4]; bits [3:0] are ignored.
REQ-013 SHALL use these fields for LOADI and OUT: reg=[9:8], imm=[7:0] (imm is used by LOADI only).
REQ-014 SHALL have three FSM states: IDLE, EXEC and OUT_WAIT.
REQ-015 SHALL drive instr_ready=1 only in IDLE; a transfer occurs when instr_valid and instr_ready are both 1 at a rising edge.
REQ-016 IDLE transitions: LOADI writes imm into reg at the accept edge and stays in IDLE; NOP changes nothing and stays in IDLE; an ALU instruction latches the instruction and goes to EXEC; OUT latches the value of reg into result and goes to OUT_WAIT.
REQ-017 In EXEC, SHALL drive alu_a=r[srcA], alu_b=r[srcB], alu_op=op and alu_carry=flag_c.
REQ-018 At the end of EXEC, SHALL write alu_c into r[dst], alu_carry_out into flag_c and alu_zero into flag_z, then return to IDLE; ALU latency is one cycle and throughput is one ALU instruction per two cycles.
REQ-019 Outside EXEC, SHALL drive alu_a, alu_b and alu_op to 0 and alu_carry to flag_c.
REQ-020 When dst equals srcA or srcB, operands SHALL be the pre-write values.
REQ-021 SHALL change flags only at the end of EXEC, for all 16 ops; LOADI, OUT and NOP leave the flags unchanged.
REQ-022 In OUT_WAIT, SHALL hold result_valid=1 and result stable until result_ready=1 at an edge, then return to IDLE.
REQ-023 If result_ready is already 1 on the first OUT_WAIT cycle, SHALL return to IDLE at that edge.
REQ-024 SHALL hold instr_ready=0 in EXEC and OUT_WAIT, so instr_valid is ignored and the instruction is not consumed.
REQ-025 The combinational path from alu_c to a register input SHALL be the only path through the ALU; there is no path from instr to the alu_* outputs.

Reset
REQ-030 While reset is asserted: state=IDLE, r0 to r3 = RESET_VAL, flag_c=0, flag_z=0, result=0, result_valid=0, instr_ready=0.
REQ-031 After reset deasserts, SHALL set instr_ready=1 from the first clock edge.
REQ-032 Reset asserted mid-EXEC SHALL suppress the register and flag write.
REQ-033 Reset asserted mid-OUT_WAIT SHALL drop result_valid immediately, without waiting for a clock edge.

Structure
REQ-040 Package alu_seq_pkg SHALL hold the class encodings, the state enum and the 4-bit opcode constants: ADD=0, ADC=1, SUB=2, SBC=3, OR=4, AND=5, NOT=6, XOR=7, PASSA=8, PASSB=9, NEG=10, CMP=11, SHL=12, SHR=13, SHLC=14, SHRC=15.
REQ-041 The register file SHALL be the sub-module regfile4x8: two async read ports, one sync write port, async reset.

Verification
REQ-050 The bench SHALL connect the team's alu to the alu_* ports and cover these scenarios:
- LOADI r0=F0, LOADI r1=20, then ADD r2=r0+r1 -> r2=10, flag_c=1, flag_z=0; instr_ready is low exactly one cycle.
- With flag_c=1, ADC r3=r1+r1 -> r3=41, flag_c=0.
- SUB r0=r0-r0 -> r0=00, flag_z=1, flag_c=0; operands are the pre-write values.
- OUT r3 with result_ready held low for 3 cycles -> result_valid=1 with result=41 for 4 cycles; one transfer; instr_valid ignored throughout.
- Reset asserted mid-EXEC of ADD -> destination keeps RESET_VAL, flags 0, result_valid 0 asynchronously.
- NOP back-to-back with LOADI at full rate -> one instruction accepted per cycle; flags unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings, FSM states and ALU opcodes for the ALU sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_LOADI = 2'b01,
    CLS_OUT   = 2'b10,
    CLS_NOP   = 2'b11
  } cls_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    OUT_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_NEG   = 4'd10;
  localparam logic [3:0] OP_CMP   = 4'd11;
  localparam logic [3:0] OP_SHL   = 4'd12;
  localparam logic [3:0] OP_SHR   = 4'd13;
  localparam logic [3:0] OP_SHLC  = 4'd14;
  localparam logic [3:0] OP_SHRC  = 4'd15;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
  } alu_instr_t;

  function automatic cls_t cls_of(input logic [15:0] w);
    return cls_t'(w[15:14]);
  endfunction

  function automatic alu_instr_t alu_fields(input logic [15:0] w);
    return alu_instr_t'(w[13:4]);
  endfunction
endpackage

// File: rtl/regfile4x8.sv
// regfile4x8: four 8-bit registers, two async read ports, one sync write port
module regfile4x8 #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr_a,
  input  logic [1:0] addr_b,
  output logic [7:0] data_a,
  output logic [7:0] data_b,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata
);
  logic [7:0] r [4];

  // storage: async reset to RESET_VAL, single write per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r[i] <= RESET_VAL;
    end else if (we) begin
      r[waddr] <= wdata;
    end
  end

  assign data_a = r[addr_a];
  assign data_b = r[addr_b];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches 16-bit instructions, drives an external ALU and returns OUT results
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        result_ready,
  output logic        result_valid,
  output logic [7:0]  result,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_carry,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_c,
  input  logic        alu_carry_out,
  input  logic        alu_zero,
  output logic        flag_c,
  output logic        flag_z
);
  state_t     state;
  alu_instr_t cur;
  cls_t       cls;
  logic       accept;
  logic       exec;
  logic [1:0] addr_a;
  logic [1:0] addr_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;

  assign cls    = cls_of(instr);
  assign accept = instr_valid && instr_ready;
  assign exec   = state == EXEC;

  // operand/write muxing: ALU operands only come from the latched instruction and are zero outside EXEC
  always_comb begin
    addr_a    = cur.src_a;
    addr_b    = exec ? cur.src_b : instr[9:8];
    alu_a     = exec ? data_a : 8'h00;
    alu_b     = exec ? data_b : 8'h00;
    alu_op    = exec ? cur.op : 4'h0;
    alu_carry = flag_c;
    we        = exec || (accept && cls == CLS_LOADI);
    waddr     = exec ? cur.dst : instr[9:8];
    wdata     = exec ? alu_c : instr[7:0];
  end

  regfile4x8 #(.RESET_VAL(RESET_VAL)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .data_a (data_a),
    .data_b (data_b),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  // sequencer FSM with registered handshake outputs and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      instr_ready  <= 1'b0;
      result_valid <= 1'b0;
      result       <= 8'h00;
      flag_c       <= 1'b0;
      flag_z       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (accept && cls == CLS_ALU) begin
            cur         <= alu_fields(instr);
            instr_ready <= 1'b0;
            state       <= EXEC;
          end else if (accept && cls == CLS_OUT) begin
            result       <= data_b;
            result_valid <= 1'b1;
            instr_ready  <= 1'b0;
            state        <= OUT_WAIT;
          end
        end
        EXEC: begin
          flag_c      <= alu_carry_out;
          flag_z      <= alu_zero;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        OUT_WAIT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            instr_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          instr_ready  <= 1'b0;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven and scoreboarded bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic        result_ready = 1'b1;
  logic        result_valid;
  logic [7:0]  result;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_carry;
  logic [3:0]  alu_op;
  logic [7:0]  alu_c;
  logic        alu_carry_out;
  logic        alu_zero;
  logic        flag_c;
  logic        flag_z;

  int checks = 0;
  int passes = 0;
  int xfers  = 0;
  logic [7:0] q[$];

  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs [21];

  alu_sequencer #(.RESET_VAL(8'h5A)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .result_ready  (result_ready),
    .result_valid  (result_valid),
    .result        (result),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry     (alu_carry),
    .alu_op        (alu_op),
    .alu_c         (alu_c),
    .alu_carry_out (alu_carry_out),
    .alu_zero      (alu_zero),
    .flag_c        (flag_c),
    .flag_z        (flag_z)
  );

  always #5 clk = ~clk;

  // team ALU: carry is the borrow for subtracts, shifts move the dropped bit into carry
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_op)
      OP_ADD:   t = {1'b0, alu_a} + {1'b0, alu_b};
      OP_ADC:   t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry};
      OP_SUB:   t = {1'b0, alu_a} - {1'b0, alu_b};
      OP_SBC:   t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_carry};
      OP_OR:    t = {1'b0, alu_a | alu_b};
      OP_AND:   t = {1'b0, alu_a & alu_b};
      OP_NOT:   t = {1'b0, ~alu_a};
      OP_XOR:   t = {1'b0, alu_a ^ alu_b};
      OP_PASSA: t = {1'b0, alu_a};
      OP_PASSB: t = {1'b0, alu_b};
      OP_NEG:   t = 9'h000 - {1'b0, alu_a};
      OP_CMP:   t = {alu_a < alu_b, alu_a};
      OP_SHL:   t = {alu_a, 1'b0};
      OP_SHR:   t = {alu_a[0], 1'b0, alu_a[7:1]};
      OP_SHLC:  t = {alu_a, alu_carry};
      OP_SHRC:  t = {alu_a[0], alu_carry, alu_a[7:1]};
      default:  t = 9'h000;
    endcase
    alu_c         = t[7:0];
    alu_carry_out = t[8];
    alu_zero      = (alu_op == OP_CMP) ? (alu_a == alu_b) : (t[7:0] == 8'h00);
  end

  function automatic logic [15:0] enc_alu(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
    return {2'b00, op, d, a, b, 4'h0};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [1:0] r, input logic [7:0] imm);
    return {2'b01, 4'h0, r, imm};
  endfunction

  function automatic logic [15:0] enc_out(input logic [1:0] r);
    return {2'b10, 4'h0, r, 8'h00};
  endfunction

  localparam logic [15:0] NOP_W = 16'hC000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {7'b0, instr_ready}, 8'd1);
    instr_valid = 1'b1;
    instr = w;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // consumer side of the scoreboard: a transfer happens at the next rising edge
  always begin
    @(negedge clk);
    #1;
    if (result_valid && result_ready) begin
      xfers++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got %h with no result expected at %0t", result, $time);
      end else begin
        check("result", result, q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [15:0] seq [5];
    vecs[0]  = '{enc_ldi(2'd0, 8'hF0),                 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{enc_ldi(2'd1, 8'h20),                 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1),    8'h00, 1'b1, 1'b0};
    vecs[3]  = '{enc_out(2'd2),                        8'h10, 1'b1, 1'b0};
    vecs[4]  = '{enc_alu(OP_ADC, 2'd3, 2'd1, 2'd1),    8'h00, 1'b0, 1'b0};
    vecs[5]  = '{enc_out(2'd3),                        8'h41, 1'b0, 1'b0};
    vecs[6]  = '{enc_alu(OP_SUB, 2'd0, 2'd0, 2'd0),    8'h00, 1'b0, 1'b1};
    vecs[7]  = '{enc_out(2'd0),                        8'h00, 1'b0, 1'b1};
    vecs[8]  = '{NOP_W,                                8'h00, 1'b0, 1'b1};
    vecs[9]  = '{enc_ldi(2'd1, 8'h05),                 8'h00, 1'b0, 1'b1};
    vecs[10] = '{enc_alu(OP_SUB, 2'd1, 2'd1, 2'd3),    8'h00, 1'b1, 1'b0};
    vecs[11] = '{enc_out(2'd1),                        8'hC4, 1'b1, 1'b0};
    vecs[12] = '{enc_alu(OP_SHL, 2'd2, 2'd2, 2'd0),    8'h00, 1'b0, 1'b0};
    vecs[13] = '{enc_alu(OP_XOR, 2'd3, 2'd3, 2'd3),    8'h00, 1'b0, 1'b1};
    vecs[14] = '{enc_out(2'd3),                        8'h00, 1'b0, 1'b1};
    vecs[15] = '{enc_ldi(2'd0, 8'h80),                 8'h00, 1'b0, 1'b1};
    vecs[16] = '{enc_alu(OP_SHLC, 2'd0, 2'd0, 2'd0),   8'h00, 1'b1, 1'b1};
    vecs[17] = '{enc_alu(OP_SHRC, 2'd1, 2'd1, 2'd0),   8'h00, 1'b0, 1'b0};
    vecs[18] = '{enc_out(2'd1),                        8'hE2, 1'b0, 1'b0};
    vecs[19] = '{enc_alu(OP_PASSB, 2'd2, 2'd0, 2'd1),  8'h00, 1'b0, 1'b0};
    vecs[20] = '{enc_out(2'd2),                        8'hE2, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_instr_ready", {7'b0, instr_ready}, 8'd0);
    check("rst_result_valid", {7'b0, result_valid}, 8'd0);
    check("rst_flag_c", {7'b0, flag_c}, 8'd0);
    check("rst_flag_z", {7'b0, flag_z}, 8'd0);
    check("rst_result", result, 8'h00);
    reset = 1'b0;
    #1;
    check("ready_before_edge", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    check("ready_first_edge", {7'b0, instr_ready}, 8'd1);
    q.push_back(8'h5A);
    send(enc_out(2'd3));

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].w[15:14] == CLS_OUT) q.push_back(vecs[i].res);
      send(vecs[i].w);
      if (vecs[i].w[15:14] == CLS_ALU) check("exec_ready_low", {7'b0, instr_ready}, 8'd0);
      @(negedge clk);
      if (vecs[i].w[15:14] == CLS_ALU) check("exec_ready_back", {7'b0, instr_ready}, 8'd1);
      check("vec_flag_c", {7'b0, flag_c}, {7'b0, vecs[i].c});
      check("vec_flag_z", {7'b0, flag_z}, {7'b0, vecs[i].z});
    end

    send(enc_ldi(2'd3, 8'h41));
    @(negedge clk);
    check("hold_start_ready", {7'b0, instr_ready}, 8'd1);
    n0 = xfers;
    result_ready = 1'b0;
    q.push_back(8'h41);
    instr = enc_out(2'd3);
    instr_valid = 1'b1;
    @(negedge clk);
    instr = enc_ldi(2'd3, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", {7'b0, result_valid}, 8'd1);
      check("hold_result", result, 8'h41);
      check("hold_ready_low", {7'b0, instr_ready}, 8'd0);
      if (i == 3) begin
        result_ready = 1'b1;
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("hold_done_valid", {7'b0, result_valid}, 8'd0);
    check("hold_one_transfer", 8'(xfers - n0), 8'd1);
    q.push_back(8'h41);
    send(enc_out(2'd3));

    send(enc_ldi(2'd0, 8'hFF));
    send(enc_ldi(2'd1, 8'h01));
    send(enc_alu(OP_ADD, 2'd3, 2'd0, 2'd1));
    @(negedge clk);
    check("pre_rst_flag_c", {7'b0, flag_c}, 8'd1);
    check("pre_rst_flag_z", {7'b0, flag_z}, 8'd1);
    @(negedge clk);
    instr = enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("exec_rst_flag_c", {7'b0, flag_c}, 8'd0);
    check("exec_rst_flag_z", {7'b0, flag_z}, 8'd0);
    check("exec_rst_ready", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    q.push_back(8'h5A);
    send(enc_out(2'd2));

    @(negedge clk);
    result_ready = 1'b0;
    send(enc_out(2'd0));
    check("ow_valid", {7'b0, result_valid}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ow_rst_valid", {7'b0, result_valid}, 8'd0);
    check("ow_rst_result", result, 8'h00);
    check("ow_rst_ready", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    result_ready = 1'b1;
    #1;
    check("ow_rel_ready", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    check("ow_rel_ready_edge", {7'b0, instr_ready}, 8'd1);

    send(enc_ldi(2'd0, 8'hFF));
    send(enc_ldi(2'd1, 8'h01));
    send(enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1));
    @(negedge clk);
    check("fr_pre_flag_c", {7'b0, flag_c}, 8'd1);
    check("fr_pre_flag_z", {7'b0, flag_z}, 8'd1);
    seq[0] = NOP_W;
    seq[1] = enc_ldi(2'd0, 8'h11);
    seq[2] = NOP_W;
    seq[3] = enc_ldi(2'd1, 8'h22);
    seq[4] = NOP_W;
    for (int i = 0; i < 5; i++) begin
      check("full_rate_ready", {7'b0, instr_ready}, 8'd1);
      instr = seq[i];
      instr_valid = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("fr_flag_c", {7'b0, flag_c}, 8'd1);
    check("fr_flag_z", {7'b0, flag_z}, 8'd1);
    q.push_back(8'h11);
    send(enc_out(2'd0));
    q.push_back(8'h22);
    send(enc_out(2'd1));

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    check("queue_empty", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
